mux41_scan_serializer: RTL and testbench
========================================

// Module: mux41_scan_serializer
// PURPOSE
//   Upstream controller for the 4:1 bit mux. Accepts a 4-bit word on a valid/ready
//   handshake and holds it on the mux data inputs. Steps the mux select through all
//   four channels and registers each returned mux bit. Emits the bits as a serial
//   stream with its own valid/ready handshake. Mux is combinational: mux_y is valid
//   in the same cycle as mux_s/mux_i.
// PARAMETERS
//   MSB_FIRST   0   0: select order 0,1,2,3; 1: select order 3,2,1,0
//   GAP_CYCLES  0   idle cycles inserted after the last bit of a word (0..255)
//   CNT_W       8   width of words_sent counter
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous reset, active-low
//   in_data     in   4      parallel word to serialize
//   in_valid    in   1      in_data valid
//   in_ready    out  1      block can accept a word (IDLE only)
//   mux_i       out  4      data inputs driven to the 4:1 mux (latched word)
//   mux_s       out  2      select driven to the 4:1 mux
//   mux_y       in   1      selected bit returned from the mux
//   ser_bit     out  1      serial output bit (registered)
//   ser_valid   out  1      ser_bit valid
//   ser_last    out  1      ser_bit is the 4th bit of the word
//   ser_ready   in   1      downstream accepts ser_bit
//   busy        out  1      high in any state other than IDLE
//   words_sent  out  CNT_W  count of completed words, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; mux_i=0, mux_s=0, ser_bit=0, ser_valid=0,
//     ser_last=0, busy=0, words_sent=0, in_ready=1 after release.
//   - FSM states: IDLE, SAMPLE, HOLD, GAP.
//   - IDLE: in_ready=1. On in_valid&&in_ready: mux_i<=in_data, mux_s<=first index
//     (0, or 3 if MSB_FIRST), idx<=0 -> SAMPLE. in_valid without handshake is ignored.
//   - SAMPLE (1 cycle): ser_bit<=mux_y, ser_valid<=1, ser_last<=(idx==3) -> HOLD.
//   - HOLD: ser_valid, ser_bit and ser_last stay stable until ser_ready=1.
//     On handshake, ser_valid<=0.
//     If not last: mux_s steps +1 (or -1 if MSB_FIRST), idx+1 -> SAMPLE.
//     If last: words_sent+1 (wraps) -> GAP if GAP_CYCLES>0, else -> IDLE.
//   - GAP: counts GAP_CYCLES cycles -> IDLE. in_ready stays 0.
//   - mux_i is held constant from accept until the next accept. mux_s changes only on
//     the accept or on a HOLD handshake, never in SAMPLE.
//   - Latency: accept at edge N -> SAMPLE in cycle N+1 -> first ser_valid=1 in cycle N+2.
//     Minimum 2 cycles per bit and 8 cycles per word + GAP_CYCLES + 1 IDLE cycle.
//   - ser_ready held high while ser_valid=0 has no effect.
//   - Next word cannot be accepted in the same cycle as the last-bit handshake; it is
//     accepted in IDLE.
//   - Reset mid-word: aborts immediately. The partial word is discarded, no ser_last is
//     emitted, and words_sent is not incremented.
//   - No combinational path from ser_ready or in_valid to any output except through
//     state registers.
// TESTING
//   1. Reset: assert rst_n=0 mid-HOLD -> all outputs 0 at once; after release
//      in_ready=1, busy=0.
//   2. MSB_FIRST=0, in_data=4'b1010, ser_ready=1 -> mux_s 0,1,2,3; bits 0,1,0,1;
//      ser_last only on 4th; words_sent=1.
//   3. MSB_FIRST=1, in_data=4'b0011 -> mux_s 3,2,1,0; bits 0,0,1,1.
//   4. Backpressure: ser_ready=0 for 5 cycles on bit 2 -> ser_bit and mux_s stable,
//      no bit lost or duplicated.
//   5. GAP_CYCLES=3, back-to-back in_valid -> in_ready low for exactly 3 GAP cycles
//      after the last handshake, then high for 1 IDLE cycle.
//   6. Send 256 words with CNT_W=8 -> words_sent wraps to 0. Bench model checks every
//      bit equals in_data[mux_s].

Source files
------------

// File: rtl/mux41_scan_serializer_if.sv
// Bus bundle between the scan serializer, its word source, the 4:1 mux and the serial sink.
// Carries both valid/ready handshakes plus the mux data, select and returned bit.
// master = serializer side, slave = environment side (source, mux and sink).
interface mux41_scan_serializer_if;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] mux_i;
   logic [1:0] mux_s;
   logic       mux_y;
   logic       ser_bit;
   logic       ser_valid;
   logic       ser_last;
   logic       ser_ready;

   modport master (
      input  in_data, in_valid, mux_y, ser_ready,
      output in_ready, mux_i, mux_s, ser_bit, ser_valid, ser_last
   );

   modport slave (
      output in_data, in_valid, mux_y, ser_ready,
      input  in_ready, mux_i, mux_s, ser_bit, ser_valid, ser_last
   );
endinterface

// File: rtl/mux41_scan_serializer.sv
// Latches a 4-bit word onto an external 4:1 mux, scans its select and streams the returned bits.
// Latency: accept at edge N, first ser_valid in cycle N+2; 2 cycles per bit minimum.
// Backpressure: ser_ready low freezes the held bit and mux_s; in_ready is high only in IDLE.
module mux41_scan_serializer #(
   parameter bit MSB_FIRST  = 1'b0,
   parameter int GAP_CYCLES = 0,
   parameter int CNT_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mux41_scan_serializer_if.master bus,
   output logic                    busy,
   output logic [CNT_W-1:0]        words_sent
);
   typedef enum logic [1:0] {IDLE, SAMPLE, HOLD, GAP} state_t;

   localparam logic [1:0] FIRST_SEL = MSB_FIRST ? 2'd3 : 2'd0;
   // Terminal count of the gap counter; irrelevant when GAP_CYCLES is 0 since GAP is skipped.
   localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

   state_t     state, state_nxt;
   logic [1:0] idx;
   logic [7:0] gap_cnt;
   logic [3:0] mux_i;
   logic [1:0] mux_s;
   logic [1:0] sel_step;
   logic       ser_bit;
   logic       ser_valid;
   logic       ser_last;
   logic       last_bit;

   assign sel_step = MSB_FIRST ? (mux_s - 2'd1) : (mux_s + 2'd1);
   assign last_bit = (idx == 2'd3);

   // Outputs come straight from registers so ser_ready/in_valid never reach them combinationally.
   assign bus.in_ready  = (state == IDLE);
   assign bus.mux_i     = mux_i;
   assign bus.mux_s     = mux_s;
   assign bus.ser_bit   = ser_bit;
   assign bus.ser_valid = ser_valid;
   assign bus.ser_last  = ser_last;
   assign busy          = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: one SAMPLE/HOLD pair per bit, optional GAP after the last bit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = HOLD;
         HOLD: begin
            if (bus.ser_ready) begin
               if (!last_bit)            state_nxt = SAMPLE;
               else if (GAP_CYCLES > 0)  state_nxt = GAP;
               else                      state_nxt = IDLE;
            end
         end
         GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: word latch, select stepping, bit capture, gap counter and completed-word count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_i      <= 4'd0;
         mux_s      <= 2'd0;
         idx        <= 2'd0;
         gap_cnt    <= 8'd0;
         ser_bit    <= 1'b0;
         ser_valid  <= 1'b0;
         ser_last   <= 1'b0;
         words_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mux_i <= bus.in_data;
                  mux_s <= FIRST_SEL;
                  idx   <= 2'd0;
               end
            end
            SAMPLE: begin
               // Mux is combinational, so mux_y already reflects mux_i[mux_s] this cycle.
               ser_bit   <= bus.mux_y;
               ser_valid <= 1'b1;
               ser_last  <= last_bit;
            end
            HOLD: begin
               if (bus.ser_ready) begin
                  ser_valid <= 1'b0;
                  ser_last  <= 1'b0;
                  if (!last_bit) begin
                     mux_s <= sel_step;
                     idx   <= idx + 2'd1;
                  end else begin
                     words_sent <= words_sent + CNT_W'(1);
                     gap_cnt    <= 8'd0;
                  end
               end
            end
            GAP:     gap_cnt <= gap_cnt + 8'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mux41_scan_serializer.sv
// Bench for mux41_scan_serializer: u0 is LSB-first with no gap, u1 is MSB-first with a 3-cycle gap.
// Expected bits/selects/last flags are queued when a word is driven and popped on each serial handshake.
// Table vectors cover the basic order; hand sequences cover reset mid-word, backpressure, gap and wrap.
module tb_mux41_scan_serializer;
   localparam int CNT_W = 8;

   typedef struct {
      logic       b;
      logic       last;
      logic [1:0] s;
   } exp_t;

   typedef struct {
      logic [3:0] data;
      logic [3:0] lsb_stream;  // bit k = k-th serial bit, LSB-first order
      logic [3:0] msb_stream;  // bit k = k-th serial bit, MSB-first order
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [1:0][3:0]       d;
   logic [1:0]            v;
   logic [1:0]            r;
   logic [1:0]            rdy, sv, sb, sl, busy;
   logic [1:0][1:0]       ms;
   logic [1:0][3:0]       mi;
   logic [1:0][CNT_W-1:0] ws;
   logic [1:0][CNT_W-1:0] ws_exp;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mux41_scan_serializer_if bus0();
   mux41_scan_serializer_if bus1();

   // Word sources, sinks and behavioural 4:1 muxes.
   assign bus0.in_data   = d[0];
   assign bus0.in_valid  = v[0];
   assign bus0.ser_ready = r[0];
   assign bus0.mux_y     = bus0.mux_i[bus0.mux_s];
   assign bus1.in_data   = d[1];
   assign bus1.in_valid  = v[1];
   assign bus1.ser_ready = r[1];
   assign bus1.mux_y     = bus1.mux_i[bus1.mux_s];

   assign rdy[0] = bus0.in_ready;  assign rdy[1] = bus1.in_ready;
   assign sv[0]  = bus0.ser_valid; assign sv[1]  = bus1.ser_valid;
   assign sb[0]  = bus0.ser_bit;   assign sb[1]  = bus1.ser_bit;
   assign sl[0]  = bus0.ser_last;  assign sl[1]  = bus1.ser_last;
   assign ms[0]  = bus0.mux_s;     assign ms[1]  = bus1.mux_s;
   assign mi[0]  = bus0.mux_i;     assign mi[1]  = bus1.mux_i;

   mux41_scan_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0), .CNT_W(CNT_W)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy[0]), .words_sent(ws[0]));

   mux41_scan_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(3), .CNT_W(CNT_W)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy[1]), .words_sent(ws[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int qsize(input int n);
      return (n == 0) ? q0.size() : q1.size();
   endfunction

   // Queue the four expected serial beats of one word.
   task automatic push_word(input int n, input logic [3:0] stream);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.b    = stream[k];
         e.last = (k == 3);
         e.s    = (n == 0) ? 2'(k) : 2'(3 - k);
         if (n == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   // Scoreboard: every serial handshake pops one expected beat.
   always @(negedge clk) begin
      if (rst_n && sv[0] && r[0]) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL u0_extra_beat actual=handshake required=none");
         end else begin
            e0 = q0.pop_front();
            chk("u0_bit",  32'(sb[0]), 32'(e0.b));
            chk("u0_last", 32'(sl[0]), 32'(e0.last));
            chk("u0_sel",  32'(ms[0]), 32'(e0.s));
         end
      end
      if (rst_n && sv[1] && r[1]) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1_extra_beat actual=handshake required=none");
         end else begin
            e1 = q1.pop_front();
            chk("u1_bit",  32'(sb[1]), 32'(e1.b));
            chk("u1_last", 32'(sl[1]), 32'(e1.last));
            chk("u1_sel",  32'(ms[1]), 32'(e1.s));
         end
      end
   end

   // Drive one word, wait for acceptance and check the accept-to-valid latency.
   task automatic send(input int n, input logic [3:0] data, input logic [3:0] stream);
      int t;
      push_word(n, stream);
      ws_exp[n] = ws_exp[n] + CNT_W'(1);
      @(posedge clk); #1;
      d[n] = data;
      v[n] = 1'b1;
      t = 0;
      @(negedge clk);
      while (!rdy[n] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!rdy[n]) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      end
      @(posedge clk); #1;
      v[n] = 1'b0;
      chk("latched_mux_i", 32'(mi[n]), 32'(data));
      chk("busy_after_accept", 32'(busy[n]), 32'd1);
      chk("valid_in_sample", 32'(sv[n]), 32'd0);
      @(posedge clk); #1;
      chk("valid_two_after_accept", 32'(sv[n]), 32'd1);
   endtask

   // Wait until every queued beat has been handshaken; optionally jitter ser_ready.
   task automatic drain(input int n, input bit rnd);
      int t;
      t = 0;
      while (qsize(n) != 0 && t < 400) begin
         @(posedge clk); #1;
         if (rnd) r[n] = ($urandom_range(0, 3) != 0);
         t++;
      end
      if (qsize(n) != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual=%0d beats_left required=0", qsize(n));
         if (n == 0) q0.delete();
         else        q1.delete();
      end
      chk("words_sent", 32'(ws[n]), 32'(ws_exp[n]));
      // Right after the last handshake: u0 returns to IDLE, u1 enters GAP.
      chk("post_last_in_ready", 32'(rdy[n]), (n == 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      vec_t       vecs[7];
      logic [3:0] data, stream;
      logic       hb, found;
      logic [1:0] hs;
      int         t;

      vecs[0] = '{4'b1010, 4'b1010, 4'b0101};
      vecs[1] = '{4'b0011, 4'b0011, 4'b1100};
      vecs[2] = '{4'b1101, 4'b1101, 4'b1011};
      vecs[3] = '{4'b0000, 4'b0000, 4'b0000};
      vecs[4] = '{4'b1111, 4'b1111, 4'b1111};
      vecs[5] = '{4'b1000, 4'b1000, 4'b0001};
      vecs[6] = '{4'b0110, 4'b0110, 4'b0110};

      d = '0; v = '0; r = '0; ws_exp = '0;

      // Power-on reset state.
      repeat (2) @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
         chk("rst_mux_i", 32'(mi[n]), 32'd0);
         chk("rst_mux_s", 32'(ms[n]), 32'd0);
         chk("rst_ser_valid", 32'(sv[n]), 32'd0);
         chk("rst_busy", 32'(busy[n]), 32'd0);
         chk("rst_words_sent", 32'(ws[n]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready0", 32'(rdy[0]), 32'd1);
      chk("rel_in_ready1", 32'(rdy[1]), 32'd1);

      // Reset while u0 holds its first bit: outputs drop immediately, word discarded.
      r[0] = 1'b0;
      send(0, 4'b1111, 4'b1111);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_mux_i", 32'(mi[0]), 32'd0);
      chk("mid_rst_mux_s", 32'(ms[0]), 32'd0);
      chk("mid_rst_ser_bit", 32'(sb[0]), 32'd0);
      chk("mid_rst_ser_valid", 32'(sv[0]), 32'd0);
      chk("mid_rst_ser_last", 32'(sl[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy[0]), 32'd0);
      chk("mid_rst_words_sent", 32'(ws[0]), 32'd0);
      q0.delete();
      ws_exp[0] = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_in_ready", 32'(rdy[0]), 32'd1);
      chk("mid_rel_busy", 32'(busy[0]), 32'd0);

      // Table vectors through both select orders with ser_ready held high.
      r = 2'b11;
      for (int i = 0; i < 7; i++) begin
         send(0, vecs[i].data, vecs[i].lsb_stream);
         drain(0, 1'b0);
         send(1, vecs[i].data, vecs[i].msb_stream);
         drain(1, 1'b0);
      end

      // Backpressure on bit 2: held bit and select must not move for 5 cycles.
      r[0] = 1'b0;
      send(0, 4'b0110, 4'b0110);
      for (int k = 0; k < 4; k++) begin
         t = 0;
         @(negedge clk);
         while (!sv[0] && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (k == 2) begin
            hb = sb[0];
            hs = ms[0];
            repeat (5) begin
               @(negedge clk);
               chk("bp_valid", 32'(sv[0]), 32'd1);
               chk("bp_bit", 32'(sb[0]), 32'(hb));
               chk("bp_sel", 32'(ms[0]), 32'(hs));
            end
         end
         @(posedge clk); #1;
         r[0] = 1'b1;
         @(posedge clk); #1;
         r[0] = 1'b0;
      end
      drain(0, 1'b0);

      // u1 back-to-back words: 3 GAP cycles with in_ready low, then one IDLE cycle.
      r[1] = 1'b1;
      push_word(1, 4'b1001);
      push_word(1, 4'b1001);
      ws_exp[1] = ws_exp[1] + CNT_W'(2);
      @(posedge clk); #1;
      d[1] = 4'b1001;
      v[1] = 1'b1;
      found = 1'b0;
      t = 0;
      while (!found && t < 100) begin
         @(negedge clk);
         t++;
         if (sv[1] && r[1] && sl[1]) found = 1'b1;
      end
      chk("gap_last_seen", 32'(found), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("gap_in_ready_low", 32'(rdy[1]), 32'd0);
         chk("gap_busy", 32'(busy[1]), 32'd1);
      end
      @(negedge clk);
      chk("gap_idle_in_ready", 32'(rdy[1]), 32'd1);
      @(negedge clk);
      chk("gap_reaccepted", 32'(rdy[1]), 32'd0);
      v[1] = 1'b0;
      drain(1, 1'b0);

      // Fresh count, then 256 random words with jittered ser_ready: counter wraps to 0.
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ws_exp = '0;
      chk("wrap_start", 32'(ws[0]), 32'd0);
      for (int w = 0; w < 256; w++) begin
         data = 4'($urandom);
         // Model: the k-th beat carries in_data[mux_s] with mux_s = k for LSB-first.
         for (int k = 0; k < 4; k++) stream[k] = data[2'(k)];
         send(0, data, stream);
         drain(0, 1'b1);
         if (w == 254) chk("count_255", 32'(ws[0]), 32'd255);
      end
      chk("wrap_to_zero", 32'(ws[0]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
